// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: per-register enables/bubbles, load-use stall, redirect flush, SYSCALL halt/GO resume.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_flow_ctrl #(
  parameter int unsigned STAGES      = 5,
  parameter int unsigned REDIR_STAGE = 3,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              CLR_n,
  input  logic              load_use,
  input  logic              redirect,
  input  logic              halt_req,
  input  logic              GO,
  output logic [STAGES-1:0] en,
  output logic [STAGES-1:0] bubble,
  output logic [STAGES-1:0] valid,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int unsigned CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  localparam logic [STAGES-1:0] EN_ALL  = '1;
  localparam logic [STAGES-1:0] EN_LU   = ~STAGES'(3);
  localparam logic [STAGES-1:0] BUB_LU  = STAGES'(4);
  localparam logic [STAGES-1:0] BUB_RD  =
    ((STAGES'(1) << REDIR_STAGE) - STAGES'(1)) & ~STAGES'(1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                r_resume_mask;
  logic                w_resume_nxt;
  logic                r_go_q;
  logic [STAGES-1:1]   r_valid;

  logic [STAGES-1:0]   w_en;
  logic [STAGES-1:0]   w_bub;
  logic                w_stall_inc;
  logic                w_flush_inc;
  logic                w_halt_eff;
  logic                w_go_rise;

  assign w_halt_eff = halt_req & ~r_resume_mask;
  assign w_go_rise  = GO & ~r_go_q;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_resume_nxt = 1'b0;
    w_en         = '0;
    w_bub        = '0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_halt_eff) begin
          w_state_nxt = S_HALT;
        end else if (redirect) begin
          w_en        = EN_ALL;
          w_bub       = BUB_RD;
          w_flush_inc = 1'b1;
        end else if (load_use) begin
          w_en        = EN_LU;
          w_bub       = BUB_LU;
          w_stall_inc = 1'b1;
          if (LOAD_LAT > 1) begin
            w_state_nxt = S_STALL;
            w_cnt_nxt   = CW'(LOAD_LAT - 1);
          end
        end else begin
          w_en = EN_ALL;
        end
      end
      S_STALL: begin
        if (w_halt_eff) begin
          w_state_nxt = S_HALT;
          w_cnt_nxt   = '0;
        end else if (redirect) begin
          w_en        = EN_ALL;
          w_bub       = BUB_RD;
          w_flush_inc = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_en        = EN_LU;
          w_bub       = BUB_LU;
          w_stall_inc = 1'b1;
          w_cnt_nxt   = r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_HALT: begin
        // Mask lets the SYSCALL in the last register drain without re-halting.
        if (w_go_rise) begin
          w_state_nxt  = S_RUN;
          w_resume_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_state       <= S_RUN;
      r_cnt         <= '0;
      r_resume_mask <= 1'b0;
      r_go_q        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_resume_mask <= w_resume_nxt;
      r_go_q        <= GO;
    end
  end

  assign en     = CLR_n ? w_en  : '0;
  assign bubble = CLR_n ? w_bub : '0;
  assign valid  = {r_valid, CLR_n};
  assign halted = (r_state == S_HALT);

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_valid <= '0;
    end else begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (en[k]) begin
          r_valid[k] <= bubble[k] ? 1'b0 : ((k == 1) ? 1'b1 : valid[k-1]);
        end
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_retire_cnt;

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (en[STAGES-1] && valid[STAGES-1]) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign retire_cnt = r_retire_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = ^{w_stall_inc, w_flush_inc};
  assign stall_cnt     = '0;
  assign flush_cnt     = '0;
  assign retire_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: directed literal checks plus randomized traffic against a per-cycle behavioural model.
module tb_pipe_flow_ctrl;

  localparam int unsigned STAGES   = 5;
  localparam int unsigned REDIR    = 3;
  localparam int unsigned LAT      = 3;
  localparam int unsigned CNT_W    = 8;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic CLR_n = 1'b1;
  logic load_use = 1'b0, redirect = 1'b0, halt_req = 1'b0, GO = 1'b0;
  logic [STAGES-1:0] en, bubble, valid;
  logic halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, retire_cnt;

  int n_vec = 0;
  int n_err = 0;

  pipe_flow_ctrl #(
    .STAGES(STAGES), .REDIR_STAGE(REDIR), .LOAD_LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .CLR_n(CLR_n), .load_use(load_use), .redirect(redirect),
    .halt_req(halt_req), .GO(GO), .en(en), .bubble(bubble), .valid(valid),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state expressed as "halted", "remaining frozen cycles" and a valid shift list.
  bit        m_halted, m_mask, m_gop;
  int        m_left;
  bit [4:0]  m_v;
  bit [7:0]  m_st, m_fl, m_rt;

  always @(negedge clk) begin
    logic [4:0] xe, xb, xv;
    bit nh, nmask;
    int nleft;
    xe = '0; xb = '0; xv = '0;
    nh = m_halted; nmask = 1'b0; nleft = m_left;
    if (!CLR_n) begin
      m_halted = 0; m_mask = 0; m_gop = 0; m_left = 0; m_v = '0;
      m_st = 0; m_fl = 0; m_rt = 0;
      nh = 0; nleft = 0;
    end else begin
      xv = {m_v[4:1], 1'b1};
      if (m_halted) begin
        if (GO && !m_gop) begin
          nh = 0; nmask = 1;
        end
      end else if (halt_req && !m_mask) begin
        nh = 1; nleft = 0;
      end else if (redirect) begin
        xe = 5'b11111; xb = 5'b00110; nleft = 0;
      end else if (m_left > 0 || load_use) begin
        xe = 5'b11100; xb = 5'b00100;
        nleft = (m_left > 0) ? m_left - 1 : int'(LAT) - 1;
      end else begin
        xe = 5'b11111;
      end
    end
    chk("en", 32'(en), 32'(xe));
    chk("bubble", 32'(bubble), 32'(xb));
    chk("valid", 32'(valid), 32'(xv));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("stall_cnt", 32'(stall_cnt), PERF ? 32'(m_st) : 32'd0);
    chk("flush_cnt", 32'(flush_cnt), PERF ? 32'(m_fl) : 32'd0);
    chk("retire_cnt", 32'(retire_cnt), PERF ? 32'(m_rt) : 32'd0);
    if (CLR_n) begin
      if (xe[4] && xv[4]) m_rt++;
      if (xb == 5'b00110) m_fl++;
      if (xb == 5'b00100) m_st++;
      for (int k = 4; k >= 1; k--) begin
        if (xe[k]) m_v[k] = xb[k] ? 1'b0 : ((k == 1) ? 1'b1 : m_v[k-1]);
      end
      m_halted = nh; m_mask = nmask; m_left = nleft; m_gop = GO;
    end
  end

  task automatic step(input bit rn, input bit lu, input bit rd, input bit hr, input bit g);
    @(posedge clk);
    #1;
    CLR_n = rn; load_use = lu; redirect = rd; halt_req = hr; GO = g;
    #1;
  endtask

  initial begin
    #1 CLR_n = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    step(1, 0, 0, 0, 0);
    chk("free_en", 32'(en), 32'h1F);
    chk("free_bub", 32'(bubble), 32'd0);
    repeat (2) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("fill_c4", 32'(valid), 32'h0F);
    step(1, 0, 0, 0, 0);
    chk("fill_c5", 32'(valid), 32'h1F);
    repeat (5) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("retire6", 32'(retire_cnt), PERF ? 32'd6 : 32'd0);

    step(1, 1, 0, 0, 0);
    chk("lu_en0", 32'(en), 32'h1C);
    chk("lu_bub0", 32'(bubble), 32'h04);
    step(1, 0, 0, 0, 0);
    chk("lu_en1", 32'(en), 32'h1C);
    chk("lu_valid1", 32'(valid), 32'h1B);
    step(1, 0, 0, 0, 0);
    chk("lu_en2", 32'(en), 32'h1C);
    step(1, 0, 0, 0, 0);
    chk("lu_en3", 32'(en), 32'h1F);
    chk("lu_bub3", 32'(bubble), 32'd0);
    chk("lu_valid3", 32'(valid), 32'h03);
    chk("lu_stall3", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);

    step(1, 1, 1, 0, 0);
    chk("rdlu_en", 32'(en), 32'h1F);
    chk("rdlu_bub", 32'(bubble), 32'h06);
    step(1, 0, 0, 0, 0);
    chk("rdlu_flush", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
    chk("rdlu_stall", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);

    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("strd_en", 32'(en), 32'h1F);
    chk("strd_bub", 32'(bubble), 32'h06);
    step(1, 0, 0, 0, 0);
    chk("strd_after_en", 32'(en), 32'h1F);
    chk("strd_after_bub", 32'(bubble), 32'd0);
    chk("strd_stall", 32'(stall_cnt), PERF ? 32'd4 : 32'd0);

    step(1, 0, 0, 1, 1);
    chk("h_en", 32'(en), 32'd0);
    chk("h_halted0", 32'(halted), 32'd0);
    repeat (4) step(1, 0, 0, 1, 1);
    chk("h_hold", 32'(halted), 32'd1);
    step(1, 0, 0, 1, 0);
    step(1, 1, 1, 1, 1);
    chk("h_edge_en", 32'(en), 32'd0);
    chk("h_edge_halted", 32'(halted), 32'd1);
    step(1, 0, 0, 1, 1);
    chk("h_res_halted", 32'(halted), 32'd0);
    chk("h_res_en", 32'(en), 32'h1F);
    step(1, 0, 0, 1, 1);
    chk("h_rehalt_en", 32'(en), 32'd0);
    step(1, 0, 0, 1, 1);
    chk("h_rehalt", 32'(halted), 32'd1);

    step(0, 0, 0, 1, 1);
    chk("hr_halted", 32'(halted), 32'd0);
    chk("hr_valid", 32'(valid), 32'd0);
    chk("hr_en", 32'(en), 32'd0);
    chk("hr_retire", 32'(retire_cnt), 32'd0);
    step(1, 0, 0, 0, 0);
    chk("hr_after_en", 32'(en), 32'h1F);

    for (int i = 0; i < 4000; i++) begin
      bit rn, lu, rd, hr, g;
      rn = ($urandom_range(0, 599) != 0);
      lu = ($urandom_range(0, 99) < 15);
      rd = ($urandom_range(0, 99) < 10);
      hr = ($urandom_range(0, 99) < 4) ? ~halt_req : halt_req;
      g  = ($urandom_range(0, 99) < 20) ? ~GO : GO;
      step(rn, lu, rd, hr, g);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
